bcd_display_driver: RTL and testbench
=====================================

Name: bcd_display_driver

Overview:
- Sits directly downstream of the four-digit push-button entry stage.
- Consumes its 14-bit binary `number` (0..9999 nominal) and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 4-digit 7-segment display.
- Also exports the BCD result for the ALU front end.

Parameters:
SCAN_DIV  1000  clock cycles each digit stays enabled before the scan advances (must be >= 2)

Ports:
clk        input   1   system clock, rising edge
rst        input   1   reset, synchronous, active-high
number     input   14  binary value from button-entry stage
bcd        output  16  converted digits; [3:0]=ones, [7:4]=tens, [11:8]=hundreds, [15:12]=thousands
bcd_valid  output  1   bcd holds a completed conversion
ovf        output  1   last converted number exceeded 9999 (clamped)
busy       output  1   conversion in progress (state != IDLE)
seg        output  7   segment drive, active-high, bit order {g,f,e,d,c,b,a}
an         output  4   digit enable, active-high, one-hot; an[0]=ones digit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: bcd=0, bcd_valid=0, ovf=0, busy=0, seg=0, an=0.
  - Internal state: FSM=IDLE, last_num=0, pending=1, scan index=0, scan divider=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Starts a conversion if pending=1 or number != last_num.
  - On start: last_num<=number; pending<=0; shift reg<=min(number,9999); ovf_next<=(number>9999); scratch BCD<=0; iteration cnt<=0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Each scratch nibble >=5 gets +3.
  - Then {scratch, shift reg} shifts left 1.
  - cnt++. After the 14th iteration (cnt==13 at the edge), go to DONE.
- DONE: bcd<=scratch; ovf<=ovf_next; bcd_valid<=1; return to IDLE.
- Latency: bcd/ovf/bcd_valid update exactly 15 clk edges after the IDLE edge that samples the change (1 start + 14 shifts, DONE on edge 15). busy=1 from the edge after start through the DONE cycle.
- Input changes while busy are not sampled. On return to IDLE, number is compared against last_num, so the final stable value is always converted, at most one conversion late.
- bcd_valid stays 1 after the first conversion and is cleared only by rst. bcd holds its old value during a conversion (no glitch on display).
- First conversion after reset is forced by pending=1, even when number=0.
- Arithmetic: scratch is 16 bits, shift reg 14 bits. Values 10000..16383 clamp to 9999 with ovf=1, so no nibble ever exceeds 9.
- Scan:
  - Divider counts 0..SCAN_DIV-1 and wraps. On wrap, the index advances 0→1→2→3→0.
  - an<=one-hot(index) and seg<=decode(bcd nibble[index]); both are registered.
  - First cycle after reset release: an=0001.
- Decode: standard 0-9 patterns (0=7'h3F, 1=7'h06, ..., 8=7'h7F, 9=7'h6F).
  - While bcd_valid=0, seg=0 (all digits blank) but an keeps scanning.
- Reset mid-conversion: aborts, outputs return to reset values, and a forced conversion follows.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: while scanning digit k (k>=1), seg=0 if that nibble and all higher nibbles are 0. The ones digit is never blanked, so 0 shows as "   0" and 42 shows as "  42". bcd output is unaffected.
- Undefined: all four digits always show their decoded value (e.g. "0042").

Test Plan:
1. Reset, number=0, release rst → busy rises next edge; 15 edges after start bcd=16'h0000, bcd_valid=1, ovf=0.
2. number=14'd1234 held after idle → bcd=16'h1234 exactly 15 edges after sampling; busy high for 15 cycles.
3. number=14'd12000 → bcd=16'h9999, ovf=1. Then number=14'd7 → bcd=16'h0007, ovf=0.
4. number changes 100→200 two cycles into a conversion → bcd reaches 16'h0100, then a second conversion yields 16'h0200 with no extra stimulus.
5. SCAN_DIV=4, bcd=16'h5678 → an cycles 0001,0010,0100,1000, each held 4 cycles; seg=7'h7F, 7'h07, 7'h7D, 7'h6D in that order.
6. LEADING_ZERO_BLANK_EN defined, number=42 → seg=0 while an=0100 and 1000. Undefined → seg=7'h3F on those digits. Also assert rst during SHIFT → all outputs 0 next edge, and a new conversion completes 15 edges after release.

Source files
------------

// File: rtl/bcd_display_driver_if.sv
// Bundle between the button-entry stage, the BCD display driver and its
// consumers: binary number in; BCD result, status and display drive out.
interface bcd_display_driver_if;
  logic [13:0] number;     // binary value from the button-entry stage
  logic [15:0] bcd;        // {thousands, hundreds, tens, ones}
  logic        bcd_valid;  // bcd holds a completed conversion
  logic        ovf;        // last converted number was clamped to 9999
  logic        busy;       // conversion in progress
  logic [6:0]  seg;        // {g,f,e,d,c,b,a}, active-high
  logic [3:0]  an;         // one-hot digit enable, an[0] = ones

  // Upstream/observer side: supplies number, watches everything else.
  modport master (
    output number,
    input  bcd, bcd_valid, ovf, busy, seg, an
  );

  // Driver side.
  modport slave (
    input  number,
    output bcd, bcd_valid, ovf, busy, seg, an
  );
endinterface

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: converts the 14-bit button-entry value to four BCD
// digits with a sequential shift-add-3 engine (1 start + 14 shift + 1 done
// cycle) and scans them onto a multiplexed 4-digit 7-segment display.
// Values above 9999 are clamped to 9999 and flagged with ovf.
// Optional build macro: LEADING_ZERO_BLANK_EN -- blanks leading zero digits
// on the display (the ones digit is always shown); bcd is unaffected.
module bcd_display_driver #(
  parameter int SCAN_DIV = 1000  // cycles per digit before the scan advances, >= 2
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_driver_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int                 DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Conversion FSM and datapath
  state_t       r_state;
  state_t       w_state_next;
  logic [13:0]  r_last;
  logic         r_pending;
  logic [13:0]  r_shift;
  logic [15:0]  r_scratch;
  logic [3:0]   r_cnt;
  logic         r_ovf_next;
  logic [15:0]  r_bcd;
  logic         r_ovf;
  logic         r_valid;
  logic         w_start;
  logic         w_busy;
  logic [13:0]  w_clamped;
  logic [15:0]  w_adj;

  // Display scan
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic [6:0]       w_seg_next;

  // Standard 0-9 segment patterns; anything else is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // A new conversion starts from IDLE when forced after reset or the input moved.
  assign w_start   = (r_state == IDLE) && (r_pending || (bus.number != r_last));
  assign w_clamped = (bus.number > 14'd9999) ? 14'd9999 : bus.number;

  // Add-3 correction: every scratch nibble >= 5 gets +3 before the shift.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_adj = r_scratch;
    for (int i = 0; i < 4; i++) begin
      if (r_scratch[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register updates from pre-edge values.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == 4'd13) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = (r_state != IDLE);
  end

  // Conversion datapath: capture on start, shift 14 times, publish on DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= '0;
      r_pending  <= 1'b1;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_last     <= bus.number;
            r_pending  <= 1'b0;
            r_shift    <= w_clamped;
            r_ovf_next <= (bus.number > 14'd9999);
            r_scratch  <= '0;
            r_cnt      <= '0;
          end
        end
        SHIFT: begin
          r_scratch <= {w_adj[14:0], r_shift[13]};
          r_shift   <= {r_shift[12:0], 1'b0};
          r_cnt     <= r_cnt + 4'd1;
        end
        DONE: begin
          r_bcd   <= r_scratch;
          r_ovf   <= r_ovf_next;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digit currently being scanned, and whether it should be blanked.
  always_comb begin
    w_nibble = r_bcd[3:0];
    w_blank  = 1'b0;
    case (r_idx)
      2'd0: w_nibble = r_bcd[3:0];
      2'd1: w_nibble = r_bcd[7:4];
      2'd2: w_nibble = r_bcd[11:8];
      2'd3: w_nibble = r_bcd[15:12];
      default: ;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (r_idx)
      2'd1:    w_blank = (r_bcd[15:4]  == 12'd0);
      2'd2:    w_blank = (r_bcd[15:8]  == 8'd0);
      2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
`endif
    w_seg_next = (!r_valid || w_blank) ? 7'h00 : seg_decode(w_nibble);
  end

  // Scan divider/index and registered digit drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
      r_an  <= '0;
      r_seg <= '0;
    end else begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      r_an  <= 4'b0001 << r_idx;
      r_seg <= w_seg_next;
    end
  end

  assign bus.bcd       = r_bcd;
  assign bus.bcd_valid = r_valid;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = w_busy;
  assign bus.seg       = r_seg;
  assign bus.an        = r_an;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Testbench for bcd_display_driver: randomized input stream checked every
// cycle against a behavioural model (decimal arithmetic, countdown latency,
// scan position from elapsed cycles), plus directed literal expectations.
module tb_bcd_display_driver;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bcd_display_driver_if bus ();

  bcd_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_pattern(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic [6:0] ref_seg(input int val, input bit valid, input int digit);
    if (!valid) return 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
    if (digit >= 1 && val < pow10(digit)) return 7'h00;
`endif
    return ref_pattern((val / pow10(digit)) % 10);
  endfunction

  bit         m_init = 0;
  int         m_cnt;      // cycles left until the result lands; 0 = idle
  bit         m_pending;
  int         m_last;
  int         m_target;
  int         m_val;
  bit         m_valid;
  bit         m_ovf;
  int         m_edges;    // clock edges since reset release
  logic [6:0] m_seg;
  logic [3:0] m_an;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_init = 1; m_cnt = 0; m_pending = 1; m_last = 0; m_target = 0;
      m_val = 0; m_valid = 0; m_ovf = 0; m_edges = 0; m_seg = 0; m_an = 0;
    end else begin
      int dig;
      m_edges++;
      dig   = ((m_edges - 1) / SCAN_DIV) % 4;
      m_an  = 4'(1 << dig);
      m_seg = ref_seg(m_val, m_valid, dig);
      if (m_cnt == 0) begin
        if (m_pending || int'(bus.number) != m_last) begin
          m_last = int'(bus.number); m_pending = 0; m_cnt = 15; m_target = int'(bus.number);
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ovf   = (m_target > 9999);
          m_val   = m_ovf ? 9999 : m_target;
          m_valid = 1;
        end
      end
    end
  end

  // Compare every cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      check("bcd",       bus.bcd,       to_bcd(m_val));
      check("bcd_valid", bus.bcd_valid, m_valid);
      check("ovf",       bus.ovf,       m_ovf);
      check("busy",      bus.busy,      (m_cnt != 0));
      check("seg",       bus.seg,       m_seg);
      check("an",        bus.an,        m_an);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) check("wait_idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic convert(input logic [13:0] v, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input string name);
    wait_idle();
    bus.number = v;
    @(negedge clk);
    check({name, "_busy_first"}, bus.busy, 1);
    repeat (14) @(negedge clk);
    check({name, "_busy_last"}, bus.busy, 1);
    @(negedge clk);
    check({name, "_bcd"}, bus.bcd, exp_bcd);
    check({name, "_ovf"}, bus.ovf, exp_ovf);
    check({name, "_busy_done"}, bus.busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] e;
    bus.number = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bcd", bus.bcd, 0);
    check("rst_valid", bus.bcd_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_seg", bus.seg, 0);
    check("rst_an", bus.an, 0);

    // Forced first conversion of 0.
    rst = 1'b0;
    @(negedge clk);
    check("t1_busy", bus.busy, 1);
    check("t1_an_first", bus.an, 4'b0001);
    repeat (14) @(negedge clk);
    check("t1_valid_early", bus.bcd_valid, 0);
    @(negedge clk);
    check("t1_valid", bus.bcd_valid, 1);
    check("t1_bcd", bus.bcd, 16'h0000);
    check("t1_ovf", bus.ovf, 0);

    convert(14'd1234,  16'h1234, 1'b0, "t2_1234");
    convert(14'd12000, 16'h9999, 1'b1, "t3_12000");
    convert(14'd7,     16'h0007, 1'b0, "t3_7");
    convert(14'd10000, 16'h9999, 1'b1, "b_10000");
    convert(14'd9999,  16'h9999, 1'b0, "b_9999");

    // Change while busy: old value lands first, new one follows unprompted.
    wait_idle();
    bus.number = 14'd100;
    repeat (2) @(negedge clk);
    bus.number = 14'd200;
    repeat (14) @(negedge clk);
    check("t4_first", bus.bcd, 16'h0100);
    repeat (16) @(negedge clk);
    check("t4_second", bus.bcd, 16'h0200);

    // Scan of 5678.
    convert(14'd5678, 16'h5678, 1'b0, "t5_5678");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      case (bus.an)
        4'b0001: e = 7'h7F;
        4'b0010: e = 7'h07;
        4'b0100: e = 7'h7D;
        4'b1000: e = 7'h6D;
        default: e = 7'h00;
      endcase
      check("t5_seg", bus.seg, e);
      @(negedge clk);
    end

    // 42: leading-zero behaviour.
    convert(14'd42, 16'h0042, 1'b0, "t6_42");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      case (bus.an)
        4'b0001: e = 7'h5B;
        4'b0010: e = 7'h66;
`ifdef LEADING_ZERO_BLANK_EN
        default: e = 7'h00;
`else
        default: e = 7'h3F;
`endif
      endcase
      check("t6_seg", bus.seg, e);
      @(negedge clk);
    end

    // Reset during SHIFT.
    wait_idle();
    bus.number = 14'd321;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6r_bcd", bus.bcd, 0);
    check("t6r_valid", bus.bcd_valid, 0);
    check("t6r_busy", bus.busy, 0);
    check("t6r_an", bus.an, 0);
    check("t6r_seg", bus.seg, 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("t6r_valid_early", bus.bcd_valid, 0);
    @(negedge clk);
    check("t6r_bcd_after", bus.bcd, 16'h0321);
    check("t6r_valid_after", bus.bcd_valid, 1);

    // Randomized stream; the per-cycle model does the checking.
    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: bus.number = 14'($urandom_range(0, 16383));
        4, 5:       bus.number = 14'($urandom_range(0, 99));
        6:          bus.number = 14'($urandom_range(9990, 10010));
        7:          bus.number = bus.number;
        8: begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
        end
        default:    bus.number = 14'($urandom_range(0, 9999));
      endcase
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    wait_idle();
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
